mdu_iter: RTL and testbench

- Iterative multiply/divide unit on the execute side of the CPU datapath.
- Consumes the two register-file read operands and produces the register-file write triple (w_en, waddr, wdata) one pulse at a time.
- Multi-cycle shift-add multiplier / restoring divider with start/busy/done handshake; the control unit stalls PC/IF while busy.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/mdu_divstep.sv | 32 +++
 rtl/mdu_iter.sv | 205 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared encodings for the execute-side multiply/divide unit.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MUL  = 2'b00,
        MDU_MULH = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_REM  = 2'b11
    } mdu_op_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mdu_divstep.sv
`default_nettype none
// ============================================================================
// Module  : mdu_divstep
// Brief   : One restoring-division step: shift in a dividend bit, trial subtract.
// Revision: 1.0
// ============================================================================
module mdu_divstep
    import cpu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   w_partial;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused_bits;

    assign w_partial = {rem_i, bit_i};
    // Extra top bit acts as the borrow flag of the trial subtraction.
    assign w_diff    = {1'b0, w_partial} - {2'b00, divisor_i};
    assign q_o       = ~w_diff[WIDTH+1];
    assign rem_o     = q_o ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];

    assign w_unused_bits = w_diff[WIDTH] ^ w_partial[WIDTH];

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module  : mdu_iter
// Brief   : Iterative shift-add multiplier / restoring divider with RF write.
//           Optional signed support enabled by defining MDU_SIGNED_EN.
// Revision: 1.0
// ============================================================================
module mdu_iter
    import cpu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             w_en,
    output logic [4:0]       waddr,
    output logic [WIDTH-1:0] wdata
);

    logic [1:0]         r_state_q;
    logic [1:0]         w_state_d;
    logic [CNT_W-1:0]   r_cnt_q;
    logic [2*WIDTH-1:0] r_prod_q;
    logic [2*WIDTH-1:0] w_prod_d;
    logic [WIDTH-1:0]   r_m_q;
    mdu_op_e            r_op_q;
    logic [4:0]         r_rd_q;
    logic [WIDTH-1:0]   r_result_q;
    logic [WIDTH-1:0]   r_prev_q;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_final;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_q;
    logic               w_iter_last;
    logic               w_accept;

    assign w_iter_last = (r_cnt_q == CNT_W'(WIDTH));
    assign w_accept    = (r_state_q == S_IDLE) && start && !cancel;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  if (start && !cancel) w_state_d = S_BUSY;
            S_BUSY: begin
                if (cancel)           w_state_d = S_IDLE;
                else if (w_iter_last) w_state_d = S_DONE;
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state_q != S_IDLE);
        done = (r_state_q == S_DONE) && !cancel;
        w_en = (r_state_q == S_DONE) && !cancel && (r_rd_q != 5'd0);
    end

    // ---------------- operand conditioning ----------------
`ifdef MDU_SIGNED_EN
    logic w_sa;
    logic w_sb;
    logic w_neg_d;
    logic r_neg_q;

    assign w_sa    = is_signed & a[WIDTH-1];
    assign w_sb    = is_signed & b[WIDTH-1];
    assign w_abs_a = w_sa ? (~a + 1'b1) : a;
    assign w_abs_b = w_sb ? (~b + 1'b1) : b;

    // Zero divisor keeps the raw all-ones quotient unsigned.
    always_comb begin
        case (op)
            2'b10:   w_neg_d = (w_sa ^ w_sb) & (|b);
            2'b11:   w_neg_d = w_sa;
            default: w_neg_d = w_sa ^ w_sb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_neg_d;
        end
    end

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_q ? (~r_prod_q + 1'b1) : r_prod_q;
    assign w_quo_fix  = r_neg_q ? (~r_prod_q[WIDTH-1:0] + 1'b1) : r_prod_q[WIDTH-1:0];
    assign w_rem_fix  = r_neg_q ? (~r_prod_q[2*WIDTH-1:WIDTH] + 1'b1)
                                : r_prod_q[2*WIDTH-1:WIDTH];
`else
    logic               w_unused_signed;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_unused_signed = is_signed;
    assign w_abs_a         = a;
    assign w_abs_b         = b;
    assign w_prod_fix      = r_prod_q;
    assign w_quo_fix       = r_prod_q[WIDTH-1:0];
    assign w_rem_fix       = r_prod_q[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        case (r_op_q)
            MDU_MUL:  w_final = w_prod_fix[WIDTH-1:0];
            MDU_MULH: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
            MDU_DIV:  w_final = w_quo_fix;
            MDU_REM:  w_final = w_rem_fix;
            default:  w_final = w_quo_fix;
        endcase
    end

    // ---------------- iteration step ----------------
    // Divide reuses the product register: upper half = remainder, lower = quotient.
    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_i     (r_prod_q[2*WIDTH-1:WIDTH]),
        .bit_i     (r_prod_q[WIDTH-1]),
        .divisor_i (r_m_q),
        .rem_o     (w_div_rem),
        .q_o       (w_div_q)
    );

    assign w_sum = {1'b0, r_prod_q[2*WIDTH-1:WIDTH]} + (r_prod_q[0] ? {1'b0, r_m_q} : '0);

    always_comb begin
        if (r_op_q[1]) begin
            w_prod_d = {w_div_rem, r_prod_q[WIDTH-2:0], w_div_q};
        end else begin
            w_prod_d = {w_sum, r_prod_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q    <= '0;
            r_prod_q   <= '0;
            r_m_q      <= '0;
            r_op_q     <= MDU_MUL;
            r_rd_q     <= '0;
            r_result_q <= '0;
            r_prev_q   <= '0;
        end else begin
            if (w_accept) begin
                r_cnt_q <= '0;
                r_op_q  <= mdu_op_e'(op);
                r_rd_q  <= rd;
                if (op[1]) begin
                    r_prod_q <= {{WIDTH{1'b0}}, w_abs_a};
                    r_m_q    <= w_abs_b;
                end else begin
                    r_prod_q <= {{WIDTH{1'b0}}, w_abs_b};
                    r_m_q    <= w_abs_a;
                end
            end else if (r_state_q == S_BUSY && !cancel) begin
                if (w_iter_last) begin
                    r_result_q <= w_final;
                    r_prev_q   <= r_result_q;
                end else begin
                    r_prod_q <= w_prod_d;
                    r_cnt_q  <= r_cnt_q + 1'b1;
                end
            end else if (r_state_q == S_DONE && cancel) begin
                // A flushed completion must not leave its value visible.
                r_result_q <= r_prev_q;
            end
        end
    end

    assign result = r_result_q;
    assign wdata  = r_result_q;
    assign waddr  = r_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_iter
// Brief   : Directed self-checking bench for mdu_iter.
// Revision: 1.0
// ============================================================================
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        is_signed;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        w_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .is_signed (is_signed),
        .cancel    (cancel),
        .a         (a),
        .b         (b),
        .rd        (rd),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .w_en      (w_en),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] r, input logic s,
                          input logic [31:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        op = o; a = x; b = y; rd = r; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~x; b = ~y; rd = ~r;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd33);
        check({tag, "_res"}, result, exp);
        check({tag, "_wdata"}, wdata, exp);
        check({tag, "_wen"}, 32'(w_en), 32'(r != 5'd0));
        check({tag, "_waddr"}, 32'(waddr), 32'(r));
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        logic [31:0] seen;
        rst = 1'b1; start = 1'b0; op = 2'b00; is_signed = 1'b0; cancel = 1'b0;
        a = '0; b = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wen", 32'(w_en), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);

        run_op("mul7x6",   2'b00, 32'd7, 32'd6, 5'd5, 1'b0, 32'd42);
        run_op("mulh_ff",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, 32'hFFFF_FFFE);
        run_op("mul_ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, 32'h0000_0001);
        run_op("mulh_sh",  2'b01, 32'h1234_5678, 32'h10, 5'd9, 1'b0, 32'h1);
        run_op("mul_sh",   2'b00, 32'h1234_5678, 32'h10, 5'd9, 1'b0, 32'h2345_6780);
        run_op("div_z",    2'b10, 32'd100, 32'd0, 5'd1, 1'b0, 32'hFFFF_FFFF);
        run_op("rem_z",    2'b11, 32'd100, 32'd0, 5'd1, 1'b0, 32'd100);
        run_op("div_big",  2'b10, 32'hFFFF_FFFF, 32'h10, 5'd7, 1'b0, 32'h0FFF_FFFF);
        run_op("rem_big",  2'b11, 32'hFFFF_FFFF, 32'h10, 5'd7, 1'b0, 32'hF);
        run_op("div_r0",   2'b10, 32'd100, 32'd7, 5'd0, 1'b0, 32'd14);
        run_op("rem_r3",   2'b11, 32'd100, 32'd7, 5'd3, 1'b0, 32'd2);

        // Cancel in BUSY: no completion, result keeps 2
        @(negedge clk);
        op = 2'b10; a = 32'd100; b = 32'd3; rd = 5'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || w_en === 1'b1) ndone++;
        end
        check("cancel_nodone", 32'(ndone), 32'd0);
        check("cancel_result", result, 32'd2);

        // Reset mid-operation
        @(negedge clk);
        op = 2'b00; a = 32'd7; b = 32'd6; rd = 5'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_result", result, 32'd0);
        check("mrst_wdata", wdata, 32'd0);
        check("mrst_waddr", 32'(waddr), 32'd0);
        check("mrst_wen", 32'(w_en), 32'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || w_en === 1'b1) ndone++;
        end
        check("mrst_nodone", 32'(ndone), 32'd0);

        // Cancel in the DONE cycle suppresses the write and restores result
        @(negedge clk);
        op = 2'b00; a = 32'd3; b = 32'd5; rd = 5'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        while (done !== 1'b1 && ndone < 40) begin
            @(posedge clk);
            #1;
            ndone++;
        end
        check("cdone_lat", 32'(ndone), 32'd33);
        cancel = 1'b1;
        #1;
        check("cdone_done", 32'(done), 32'd0);
        check("cdone_wen", 32'(w_en), 32'd0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cdone_busy", 32'(busy), 32'd0);
        check("cdone_result", result, 32'd0);

        // Second start while busy is ignored
        @(negedge clk);
        op = 2'b00; a = 32'd7; b = 32'd6; rd = 5'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = 2'b10; a = 32'd9; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        seen = '0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                seen = wdata;
            end
        end
        check("dbl_count", 32'(ndone), 32'd1);
        check("dbl_wdata", seen, 32'd42);

`ifdef MDU_SIGNED_EN
        run_op("sdiv_m7", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 32'hFFFF_FFFD);
        run_op("srem_m7", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 32'hFFFF_FFFF);
        run_op("sdiv_ov", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'h8000_0000);
        run_op("srem_ov", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1, 32'h0);
        run_op("smul_m3", 2'b00, 32'hFFFF_FFFD, 32'd4, 5'd8, 1'b1, 32'hFFFF_FFF4);
        run_op("sdiv_z",  2'b10, 32'hFFFF_FFF9, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFFF);
        run_op("srem_z",  2'b11, 32'hFFFF_FFF9, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFF9);
`else
        run_op("udiv_sig", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 32'h7FFF_FFFC);
        run_op("urem_sig", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
